// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Hits are served with no added cycles; misses stall while a dirty victim is written back and the line is refilled.
module dcache_ctrl #(
  parameter int IDX_W = 3,
  parameter int OFF_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        stall,
  output logic [12:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int TAG_W = 13 - IDX_W - OFF_W;
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << (IDX_W + OFF_W);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_arr [LINES];
  logic [15:0]        data_arr [WORDS];

  logic [TAG_W-1:0]   cpu_tag;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic               req, hit, last;
  logic               stall_c, st_hit, fill_done, arr_we;
  logic [IDX_W+OFF_W-1:0] arr_waddr;
  logic [15:0]        arr_wdata;

  assign cpu_tag = cpu_addr[12 -: TAG_W];
  assign idx     = cpu_addr[OFF_W +: IDX_W];
  assign off     = cpu_addr[OFF_W-1:0];
  assign req     = cpu_re || cpu_we;
  assign hit     = valid_q[idx] && (tag_arr[idx] == cpu_tag);
  assign last    = (cnt_q == {OFF_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    st_hit    = 1'b0;
    fill_done = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = {idx, off};
    arr_wdata = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Simultaneous re/we is a store.
            if (cpu_we) begin
              st_hit = 1'b1;
              arr_we = 1'b1;
            end else begin
              cpu_rdata = data_arr[{idx, off}];
            end
          end else begin
            stall_c = 1'b1;
            cnt_d   = '0;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        stall_c   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_arr[idx], idx, cnt_q};
        mem_wdata = data_arr[{idx, cnt_q}];
        cnt_d     = cnt_q + 1'b1;
        if (last) state_d = FILL;
      end
      FILL: begin
        stall_c   = 1'b1;
        mem_re    = 1'b1;
        mem_addr  = {cpu_tag, idx, cnt_q};
        arr_we    = 1'b1;
        arr_waddr = {idx, cnt_q};
        arr_wdata = mem_rdata;
        cnt_d     = cnt_q + 1'b1;
        if (last) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so the pipeline is released the moment reset asserts.
  assign stall = stall_c && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (st_hit) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) data_arr[arr_waddr] <= arr_wdata;
    if (fill_done) tag_arr[idx] <= cpu_tag;
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(mem_re && mem_we));

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed miss/hit/write-back/reset scenarios plus random traffic.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        stall;
  logic [12:0] mem_addr;
  logic        mem_re, mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [12:0] a; logic [15:0] d;} op_t;

  int          n_chk = 0, n_fail = 0;
  op_t         op_q[$];
  logic [15:0] rd_q[$];
  bit          chk_mem = 1'b1;
  logic [15:0] dmem    [8192];
  logic [15:0] ref_mem [8192];
  op_t         mon_e;
  logic [15:0] mon_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic er(input logic [12:0] a);
    op_q.push_back('{1'b0, a, 16'h0});
  endtask

  task automatic ew(input logic [12:0] a, input logic [15:0] d);
    op_q.push_back('{1'b1, a, d});
  endtask

  // Backing data memory: captures reads on the negedge, DUT samples next posedge.
  always @(negedge clk) begin
    if (mem_we) dmem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  // Monitor: pops expected memory operations and load data as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("no_rd_wr_overlap", {31'b0, mem_re && mem_we}, 32'd0);
      if (chk_mem && (mem_re || mem_we)) begin
        if (op_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_mem_op: got re=%0b we=%0b addr=%0h expected none", mem_re, mem_we, mem_addr);
        end else begin
          mon_e = op_q.pop_front();
          chk("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          chk("mem_re", {31'b0, mem_re}, {31'b0, !mon_e.we});
          chk("mem_addr", {19'b0, mem_addr}, {19'b0, mon_e.a});
          if (mon_e.we) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, mon_e.d});
        end
      end
      if (cpu_re && !cpu_we && !stall) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_load: got rdata=%0h expected none", cpu_rdata);
        end else begin
          mon_r = rd_q.pop_front();
          chk("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, mon_r});
        end
      end
    end
  end

  // Issue one request at posedge+1, hold it until stall drops, optionally check stall length.
  task automatic do_req(input logic [12:0] a, input logic re, input logic we, input logic [15:0] wd,
                        input logic [15:0] erd, input int est);
    int st = 0;
    if (re && !we) rd_q.push_back(erd);
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_wdata = wd;
    do begin
      @(negedge clk);
      if (stall) st++;
    end while (stall && st <= 40);
    if (stall) begin
      n_chk++; n_fail++;
      $display("FAIL stall_timeout: got %0d stall cycles expected at most 40", st);
    end else if (est >= 0) begin
      chk("stall_cycles", st, est);
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] a;
    logic [15:0] wd;
    int          op;
    for (int i = 0; i < 8192; i++) dmem[i] = 16'(i) ^ 16'hA5A5;
    dmem[4] = 16'h1111; dmem[5] = 16'h2222; dmem[6] = 16'h3333; dmem[7] = 16'h4444;
    for (int i = 0; i < 8192; i++) ref_mem[i] = dmem[i];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {19'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
    @(posedge clk); #1;

    // Clean load miss, then a hit in the same line.
    er(13'h004); er(13'h005); er(13'h006); er(13'h007);
    do_req(13'h004, 1'b1, 1'b0, 16'h0, 16'h1111, 5);
    do_req(13'h006, 1'b1, 1'b0, 16'h0, 16'h3333, 0);

    // Store hit dirties line 1, conflicting load writes it back then refills.
    do_req(13'h005, 1'b0, 1'b1, 16'hBEEF, 16'h0, 0);
    ref_mem[13'h005] = 16'hBEEF;
    ew(13'h004, 16'h1111); ew(13'h005, 16'hBEEF); ew(13'h006, 16'h3333); ew(13'h007, 16'h4444);
    er(13'h024); er(13'h025); er(13'h026); er(13'h027);
    do_req(13'h025, 1'b1, 1'b0, 16'h0, 16'hA580, 9);

    // Store miss allocates, later conflict writes the stored word back.
    er(13'h100); er(13'h101); er(13'h102); er(13'h103);
    do_req(13'h100, 1'b0, 1'b1, 16'h00AA, 16'h0, 5);
    ref_mem[13'h100] = 16'h00AA;
    ew(13'h100, 16'h00AA); ew(13'h101, 16'hA4A4); ew(13'h102, 16'hA4A7); ew(13'h103, 16'hA4A6);
    er(13'h000); er(13'h001); er(13'h002); er(13'h003);
    do_req(13'h000, 1'b1, 1'b0, 16'h0, 16'hA5A5, 9);

    // Reset during the second fill cycle.
    er(13'h200);
    cpu_addr = 13'h200; cpu_re = 1'b1; cpu_we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_fill_active", {31'b0, mem_re}, 32'd1);
    chk("t5_fill_addr", {19'b0, mem_addr}, 32'h201);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("t5_rst_stall", {31'b0, stall}, 32'd0);
    chk("t5_rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    er(13'h200); er(13'h201); er(13'h202); er(13'h203);
    do_req(13'h200, 1'b1, 1'b0, 16'h0, 16'hA7A5, 5);
    chk("memop_q_drained", op_q.size(), 32'd0);

    // Random traffic against the architectural reference memory.
    chk_mem = 1'b0;
    for (int n = 0; n < 300; n++) begin
      a  = {5'(($urandom_range(0, 3))), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wd = 16'($urandom);
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_req(a, 1'b1, 1'b0, 16'h0, ref_mem[a], -1);
      end else begin
        ref_mem[a] = wd;
        do_req(a, op == 2, 1'b1, wd, 16'h0, -1);
      end
    end

    chk("rdata_q_drained", rd_q.size(), 32'd0);
    chk("end_stall", {31'b0, stall}, 32'd0);
    chk("end_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller between the processor's load/store stage and the single-ported data memory. It serves hits in zero added cycles and stalls the pipeline on a miss. It writes back a dirty victim line and fills the new line word-by-word over the data memory's read/write strobes. It is the initiator for the data memory. It never asserts read and write to it in the same cycle.

## Interface
Parameters:
- IDX_W, 3: index bits; lines = 2^IDX_W (8).
- OFF_W, 2: word-offset bits; words per line = 2^OFF_W (4).
- TAG_W is derived as 13-IDX_W-OFF_W (8); it is not overridable.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  13  word address; tag=[12:5], index=[4:2], offset=[1:0] at defaults.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid when cpu_re && !stall.
- stall  out  1  pipeline hold. CPU keeps addr, re, we and wdata stable while it is high.
- mem_addr  out  13  data-memory address.
- mem_re  out  1  data-memory read strobe.
- mem_we  out  1  data-memory write strobe.
- mem_wdata  out  16  data-memory write data.
- mem_rdata  in  16  data-memory read data. Memory captures it on the negedge of the cycle in which mem_re is high; the controller samples it on the following posedge.

## Operation
- Storage: data array of 2^(IDX_W+OFF_W) x 16 (not reset), plus tag, valid and dirty per line. Valid and dirty are cleared by reset.
- hit = valid[idx] && tag[idx]==cpu_tag. req = cpu_re || cpu_we. If both re and we are high, the controller treats the request as a store.
- FSM states: IDLE, WB, FILL.
- IDLE:
  - req && hit, load: cpu_rdata = array word, combinationally; stall=0.
  - req && hit, store: at posedge, write cpu_wdata into the array and set dirty[idx]; stall=0.
  - req && !hit: stall=1. Next state is WB if valid && dirty, otherwise FILL. Word counter cnt is set to 0.
- WB: mem_we=1, mem_addr={tag[idx],idx,cnt}, mem_wdata=array word cnt; stall=1. cnt increments each cycle. After cnt==3, cnt resets to 0 and the FSM moves to FILL.
- FILL: mem_re=1, mem_addr={cpu_tag,idx,cnt}; stall=1. At each posedge, mem_rdata is written into word cnt. After cnt==3: tag[idx]=cpu_tag, valid=1, dirty=0, next state IDLE.
- Back in IDLE, the held request now hits and is serviced as above. A store miss therefore allocates the line, then writes it and sets dirty.
- Idle outputs: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0. cpu_rdata=0 unless the request is a load hit.
- Invariant: mem_re && mem_we is never true.

## Timing
- Reset values: state IDLE, cnt 0, all valid and dirty 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0. stall and cpu_rdata are 0 whenever no request is present.
- Hit latency is 0 extra cycles. Load data is combinational in the request cycle; store data is committed at that cycle's posedge.
- Clean miss: stall high for 5 cycles (1 IDLE-detect + 4 FILL), then 1 hit cycle with stall low.
- Dirty miss: stall high for 9 cycles (1 + 4 WB + 4 FILL).
- Write-back and fill addresses ascend from word 0 to word 3 with no gaps between them.
- A request dropped while stall is high is a CPU protocol error. The FSM still completes the line operation.
- Reset mid-WB or mid-FILL: strobes drop and stall drops immediately (asynchronously). The partial line is invalid, because all valid bits are cleared. Memory contents already written stay as written.
- Back-to-back requests to different lines: each miss is resolved independently. No request is accepted while the FSM is outside IDLE.

## Test plan
1. Reset, then load 0x0004 with mem[4..7]=0x1111..0x4444 -> stall 5 cycles; mem_re at addresses 0x0004..0x0007; then cpu_rdata=0x1111, stall=0.
2. After test 1, load 0x0006 -> stall=0 in the same cycle; cpu_rdata=0x3333; mem_re and mem_we stay 0.
3. Store 0x0005=0xBEEF (hit), then load 0x0025 (same index, tag 1) -> stall 9 cycles. mem_we writes 0x0004..0x0007 with word 0x0005=0xBEEF. mem_re reads 0x0024..0x0027. cpu_rdata=mem[0x25].
4. Store miss to 0x0100 with 0x00AA on a clean line -> 4 fill reads at 0x0100..0x0103, then array word 0=0x00AA with dirty set. A later conflict miss writes 0x00AA back to 0x0100.
5. Assert rst_n low during the second FILL cycle -> mem_re=0 and stall=0 before the next posedge. Reloading the same address misses again with a full 4-word fill.
6. Random load/store traffic against a reference memory model, with a continuous check that mem_re && mem_we never occurs and that every load returns the model's value.
